// File: rtl/mult_seq_master_if.sv
// AXI-lite bus between the multiplier sequencer (master) and the multiplier peripheral (slave).
interface mult_seq_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mult_seq_master.sv
// Sequencer that writes two operands to an AXI-lite multiplier, then reads back
// the product and overflow flag; every phase is guarded by a cycle timeout.
module mult_seq_master #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  error,
  mult_seq_master_if.master     m_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(BASE_ADDR + 16);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(BASE_ADDR + 20);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RES = ADDR_WIDTH'(BASE_ADDR + 24);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = ADDR_WIDTH'(BASE_ADDR + 28);
  localparam logic [15:0]           CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_A, WB_A, WR_B, WB_B, AR_RES, R_RES, AR_OVF, R_OVF, FIN
  } state_t;

  state_t                  state_reg, state_next;
  logic [15:0]             cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]   b_reg, b_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    error_reg, error_next;
  logic [DATA_WIDTH-1:0]   result_reg, result_next;
  logic                    overflow_reg, overflow_next;
  logic [ADDR_WIDTH-1:0]   awaddr_reg, awaddr_next;
  logic                    awvalid_reg, awvalid_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]       wstrb_reg, wstrb_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    bready_reg, bready_next;
  logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg, rready_next;
  logic                    abort;
  logic                    timeout;
  logic                    bresp_err;
  logic                    rresp_err;

  assign timeout   = (cnt_reg == CNT_LAST);
  assign bresp_err = (m_axi.bresp == 2'b10) || (m_axi.bresp == 2'b11);
  assign rresp_err = (m_axi.rresp == 2'b10) || (m_axi.rresp == 2'b11);

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      b_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      awaddr_reg   <= '0;
      awvalid_reg  <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      wvalid_reg   <= 1'b0;
      bready_reg   <= 1'b0;
      araddr_reg   <= '0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      b_reg        <= b_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      awaddr_reg   <= awaddr_next;
      awvalid_reg  <= awvalid_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
      wvalid_reg   <= wvalid_next;
      bready_reg   <= bready_next;
      araddr_reg   <= araddr_next;
      arvalid_reg  <= arvalid_next;
      rready_reg   <= rready_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + 16'd1;
    b_next        = b_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    error_next    = error_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    awaddr_next   = awaddr_reg;
    awvalid_next  = awvalid_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    wvalid_next   = wvalid_reg;
    bready_next   = bready_reg;
    araddr_next   = araddr_reg;
    arvalid_next  = arvalid_reg;
    rready_next   = rready_reg;
    abort         = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          b_next       = op_b;
          busy_next    = 1'b1;
          error_next   = 1'b0;
          awaddr_next  = ADDR_A;
          wdata_next   = op_a;
          wstrb_next   = '1;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          state_next   = WR_A;
        end
      end
      // Address and data channels retire independently; leave once both have.
      WR_A, WR_B: begin
        awvalid_next = awvalid_reg & ~m_axi.awready;
        wvalid_next  = wvalid_reg & ~m_axi.wready;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          cnt_next    = '0;
          state_next  = (state_reg == WR_A) ? WB_A : WB_B;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      WB_A, WB_B: begin
        if (m_axi.bvalid) begin
          bready_next = 1'b0;
          cnt_next    = '0;
          if (bresp_err) begin
            error_next = 1'b1;
            done_next  = 1'b1;
            state_next = FIN;
          end else if (state_reg == WB_A) begin
            awaddr_next  = ADDR_B;
            wdata_next   = b_reg;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_B;
          end else begin
            araddr_next  = ADDR_RES;
            arvalid_next = 1'b1;
            state_next   = AR_RES;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      AR_RES, AR_OVF: begin
        if (m_axi.arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          cnt_next     = '0;
          state_next   = (state_reg == AR_RES) ? R_RES : R_OVF;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      R_RES, R_OVF: begin
        if (m_axi.rvalid) begin
          rready_next = 1'b0;
          cnt_next    = '0;
          if (state_reg == R_RES) begin
            result_next = m_axi.rdata;
          end else begin
            overflow_next = m_axi.rdata[0];
          end
          if (rresp_err || state_reg == R_OVF) begin
            error_next = error_reg | rresp_err;
            done_next  = 1'b1;
            state_next = FIN;
          end else begin
            araddr_next  = ADDR_OVF;
            arvalid_next = 1'b1;
            state_next   = AR_OVF;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      FIN: begin
        cnt_next   = '0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // A stalled phase drops every handshake request and finishes with an error.
    if (abort) begin
      error_next   = 1'b1;
      done_next    = 1'b1;
      awvalid_next = 1'b0;
      wvalid_next  = 1'b0;
      bready_next  = 1'b0;
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      cnt_next     = '0;
      state_next   = FIN;
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign result        = result_reg;
  assign overflow      = overflow_reg;
  assign m_axi.awaddr  = awaddr_reg;
  assign m_axi.awvalid = awvalid_reg;
  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = wstrb_reg;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;
  assign m_axi.araddr  = araddr_reg;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

endmodule

// File: tb/tb_mult_seq_master.sv
// Bench for mult_seq_master: a reactive AXI-lite multiplier peripheral with
// configurable delays/responses, directed scenarios and randomized operations.
module tb_mult_seq_master;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BASE  = 32;
  localparam int TO    = 4;
  localparam int NEVER = 1000;
  localparam logic [AW-1:0] A_OPA = 8'(BASE + 16);
  localparam logic [AW-1:0] A_OPB = 8'(BASE + 20);
  localparam logic [AW-1:0] A_RES = 8'(BASE + 24);
  localparam logic [AW-1:0] A_OVF = 8'(BASE + 28);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] op_a = '0;
  logic [DW-1:0] op_b = '0;
  logic          busy, done, overflow, error;
  logic [DW-1:0] result;

  mult_seq_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mult_seq_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .error(error),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Peripheral behaviour knobs and observation logs
  int            aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]    bresp_a = 0, bresp_b = 0, rresp_res = 0, rresp_ovf = 0;
  logic [DW-1:0] err_res_data = 0;
  logic          err_ovf_bit = 0;
  logic [DW-1:0] reg_a = 0, reg_b = 0;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] last_ar = 0;
  int            ar_high = 0;
  bit            strb_bad = 0;

  logic [DW-1:0] exp_result = 0;
  logic          exp_ovf = 0;

  // Multiplier peripheral: ready/valid decided at negedge, so a zero delay
  // answers in the same cycle the master asks.
  initial begin
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [63:0] prod;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        continue;
      end
      if (bus.awvalid) begin
        if (aw_wait >= aw_delay) begin
          bus.awready = 1; aw_log.push_back(bus.awaddr); aw_wait = 0;
        end else begin
          bus.awready = 0; aw_wait++;
        end
      end else begin
        bus.awready = 0; aw_wait = 0;
      end
      if (bus.wvalid) begin
        if (w_wait >= w_delay) begin
          bus.wready = 1; w_log.push_back(bus.wdata); w_wait = 0;
          if (bus.wstrb !== 4'hF) strb_bad = 1;
        end else begin
          bus.wready = 0; w_wait++;
        end
      end else begin
        bus.wready = 0; w_wait = 0;
      end
      if (bus.bready) begin
        if (b_wait >= b_delay) begin
          bus.bvalid = 1; b_wait = 0; bus.bresp = 2'b00;
          if (aw_log.size() > 0 && w_log.size() > 0) begin
            if (aw_log[$] == A_OPA) begin
              reg_a = w_log[$]; bus.bresp = bresp_a;
            end else begin
              reg_b = w_log[$]; bus.bresp = bresp_b;
            end
          end
        end else begin
          bus.bvalid = 0; b_wait++;
        end
      end else begin
        bus.bvalid = 0; b_wait = 0;
      end
      if (bus.arvalid) begin
        ar_high++;
        if (ar_wait >= ar_delay) begin
          bus.arready = 1; rd_log.push_back(bus.araddr); last_ar = bus.araddr; ar_wait = 0;
        end else begin
          bus.arready = 0; ar_wait++;
        end
      end else begin
        bus.arready = 0; ar_wait = 0;
      end
      if (bus.rready) begin
        if (r_wait >= r_delay) begin
          prod = 64'(reg_a) * 64'(reg_b);
          bus.rvalid = 1; r_wait = 0;
          if (last_ar == A_RES) begin
            bus.rresp = rresp_res;
            bus.rdata = rresp_res[1] ? err_res_data : prod[31:0];
          end else begin
            bus.rresp = rresp_ovf;
            bus.rdata = {31'b0, rresp_ovf[1] ? err_ovf_bit : (prod[63:32] != 0)};
          end
        end else begin
          bus.rvalid = 0; r_wait++;
        end
      end else begin
        bus.rvalid = 0; r_wait = 0;
      end
    end
  end

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); rd_log.delete();
    ar_high = 0; strb_bad = 0;
  endtask

  task automatic set_slave(input int aw, w, b, ar, r);
    aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    bresp_a = 0; bresp_b = 0; rresp_res = 0; rresp_ovf = 0;
  endtask

  // Pulse start for one cycle; lat counts cycles with the start cycle as 1.
  task automatic run_op(input logic [DW-1:0] a, b, output bit got_done, output int lat,
                        output bit busy_seen);
    @(negedge clk);
    op_a = a; op_b = b; start = 1;
    @(posedge clk);
    #1;
    start = 0; op_a = $urandom; op_b = $urandom;
    got_done = 0; lat = 0; busy_seen = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) busy_seen = busy;
      if (done) begin
        got_done = 1; lat = k + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_status got %b exp 0000", {busy, done, error, overflow});
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL reset_result got %h exp 0", result);
    end
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b exp 00000",
                         {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    checks++;
    if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb} !== '0) begin
      errors++; $display("FAIL reset_bus got aw=%h ar=%h wd=%h ws=%h exp 0",
                         bus.awaddr, bus.araddr, bus.wdata, bus.wstrb);
    end
    rst_n = 1;
    $display("reset done");
  endtask

  task automatic test_ideal();
    bit got; int lat; bit bsy;
    clear_logs(); set_slave(0, 0, 0, 0, 0);
    run_op(32'd6, 32'd7, got, lat, bsy);
    $display("ideal: a=6 b=7 result=%0d ovf=%0d err=%0d lat=%0d", result, overflow, error, lat);
    checks++; if (!got) begin errors++; $display("FAIL ideal_done got 0 exp 1"); end
    checks++; if (lat != 10) begin errors++; $display("FAIL ideal_latency got %0d exp 10", lat); end
    checks++; if (!bsy) begin errors++; $display("FAIL ideal_busy got 0 exp 1"); end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL ideal_result got %h exp 2a", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ideal_ovf got %b exp 0", overflow); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ideal_error got %b exp 0", error); end
    checks++;
    if (!(aw_log.size() == 2 && aw_log[0] == A_OPA && aw_log[1] == A_OPB &&
          w_log.size() == 2 && w_log[0] == 32'd6 && w_log[1] == 32'd7)) begin
      errors++; $display("FAIL ideal_writes got %0d aw/%0d w exp 2/2 to %h,%h data 6,7",
                         aw_log.size(), w_log.size(), A_OPA, A_OPB);
    end
    checks++;
    if (!(rd_log.size() == 2 && rd_log[0] == A_RES && rd_log[1] == A_OVF)) begin
      errors++; $display("FAIL ideal_reads got %0d reads exp 2 to %h,%h", rd_log.size(), A_RES, A_OVF);
    end
    checks++; if (strb_bad) begin errors++; $display("FAIL ideal_wstrb got partial exp f"); end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL ideal_after got done=%b busy=%b exp 0 0", done, busy);
    end
    exp_result = 32'd42; exp_ovf = 0;
  endtask

  task automatic test_skew();
    bit got; int lat; bit bsy;
    clear_logs(); set_slave(0, 3, 0, 0, 0);
    run_op(32'hFFFF_FFFF, 32'd2, got, lat, bsy);
    $display("skew: a=ffffffff b=2 result=%h ovf=%0d err=%0d lat=%0d", result, overflow, error, lat);
    checks++; if (!got) begin errors++; $display("FAIL skew_done got 0 exp 1"); end
    checks++; if (lat != 16) begin errors++; $display("FAIL skew_latency got %0d exp 16", lat); end
    checks++;
    if (!(aw_log.size() == 2 && w_log.size() == 2 && w_log[0] == 32'hFFFF_FFFF && w_log[1] == 32'd2)) begin
      errors++; $display("FAIL skew_writes got %0d aw/%0d w exp 2/2", aw_log.size(), w_log.size());
    end
    checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL skew_result got %h exp fffffffe", result); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL skew_ovf got %b exp 1", overflow); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL skew_error got %b exp 0", error); end
    exp_result = 32'hFFFF_FFFE; exp_ovf = 1;
  endtask

  task automatic test_bresp_err();
    bit got; int lat; bit bsy;
    clear_logs(); set_slave(0, 0, 0, 0, 0);
    bresp_b = 2'b10;
    run_op($urandom, $urandom, got, lat, bsy);
    $display("bresp_err: result=%h err=%0d lat=%0d reads=%0d", result, error, lat, rd_log.size());
    checks++; if (!got) begin errors++; $display("FAIL berr_done got 0 exp 1"); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL berr_error got %b exp 1", error); end
    checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL berr_no_ar got %0d reads exp 0", rd_log.size()); end
    checks++; if (result !== exp_result) begin errors++; $display("FAIL berr_result got %h exp %h", result, exp_result); end
    checks++; if (lat != 6) begin errors++; $display("FAIL berr_latency got %0d exp 6", lat); end
    bresp_b = 0;
  endtask

  task automatic test_ar_timeout();
    bit got; int lat; bit bsy;
    clear_logs(); set_slave(0, 0, 0, NEVER, 0);
    run_op($urandom, $urandom, got, lat, bsy);
    $display("ar_timeout: err=%0d arvalid_cycles=%0d lat=%0d", error, ar_high, lat);
    checks++; if (!got) begin errors++; $display("FAIL arto_done got 0 exp 1"); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL arto_error got %b exp 1", error); end
    checks++; if (ar_high != TO) begin errors++; $display("FAIL arto_arvalid_cycles got %0d exp %0d", ar_high, TO); end
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL arto_arvalid_drop got %b exp 0", bus.arvalid); end
    checks++; if (result !== exp_result) begin errors++; $display("FAIL arto_result got %h exp %h", result, exp_result); end
  endtask

  task automatic test_start_ignored_reset();
    logic [DW-1:0] a1, b1;
    bit saw_bready, saw_rready, saw_done, got, bsy;
    int lat;
    a1 = $urandom; b1 = $urandom;
    clear_logs(); set_slave(0, 0, 2, 0, 3);
    saw_bready = 0; saw_rready = 0; saw_done = 0;
    @(negedge clk);
    op_a = a1; op_b = b1; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 0; k < 20 && !saw_bready; k++) begin
      @(negedge clk);
      saw_bready = bus.bready;
    end
    op_a = ~a1; op_b = ~b1; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int k = 0; k < 40 && !saw_rready; k++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      saw_rready = bus.rready;
    end
    checks++; if (!saw_rready) begin errors++; $display("FAIL midreset_reach_r got 0 exp 1"); end
    rst_n = 0;
    @(negedge clk);
    if (done) saw_done = 1;
    checks++;
    if ({busy, done, error, overflow, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 9'b0) begin
      errors++; $display("FAIL midreset_flags got %b exp 0",
                         {busy, done, error, overflow, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    checks++;
    if ({result, bus.awaddr, bus.araddr, bus.wdata, bus.wstrb} !== '0) begin
      errors++; $display("FAIL midreset_data got res=%h aw=%h ar=%h wd=%h exp 0", result, bus.awaddr, bus.araddr, bus.wdata);
    end
    @(negedge clk);
    if (done) saw_done = 1;
    rst_n = 1;
    repeat (2) begin @(negedge clk); if (done) saw_done = 1; end
    checks++; if (saw_done) begin errors++; $display("FAIL midreset_no_done got 1 exp 0"); end
    checks++;
    if (!(w_log.size() == 2 && w_log[0] == a1 && w_log[1] == b1)) begin
      errors++; $display("FAIL ignored_start got %0d writes exp 2 data %h,%h", w_log.size(), a1, b1);
    end
    $display("midreset: first op a=%h b=%h abandoned, writes=%0d", a1, b1, w_log.size());
    exp_result = 0; exp_ovf = 0;
    clear_logs(); set_slave(0, 0, 0, 0, 0);
    run_op(32'd1000, 32'd3000, got, lat, bsy);
    $display("post_reset: a=1000 b=3000 result=%0d lat=%0d", result, lat);
    checks++; if (!got || lat != 10) begin errors++; $display("FAIL postreset_latency got %0d exp 10", lat); end
    checks++; if (result !== 32'd3000000 || error !== 1'b0) begin
      errors++; $display("FAIL postreset_result got %h err %b exp %h err 0", result, error, 32'd3000000);
    end
    exp_result = 32'd3000000;
  endtask

  task automatic test_random();
    bit got, bsy, e_err;
    int lat, e_lat, nw, nr, wr_len, rd_len;
    logic [DW-1:0] a, b;
    logic [63:0] prod;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
      b = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
      clear_logs();
      set_slave($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
      bresp_a   = ($urandom_range(0, 7) == 0) ? 2'b10 | 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      bresp_b   = ($urandom_range(0, 7) == 0) ? 2'b10 | 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      rresp_res = ($urandom_range(0, 7) == 0) ? 2'b10 | 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      rresp_ovf = ($urandom_range(0, 7) == 0) ? 2'b10 | 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      err_res_data = exp_result; err_ovf_bit = exp_ovf;
      // Reference: walk the operation's phases in order, stopping at the first error.
      prod   = 64'(a) * 64'(b);
      wr_len = ((aw_delay > w_delay) ? aw_delay : w_delay) + 1 + b_delay + 1;
      rd_len = ar_delay + 1 + r_delay + 1;
      e_err = 0; e_lat = 2 + wr_len; nw = 1; nr = 0;
      if (bresp_a[1]) e_err = 1;
      else begin
        nw = 2; e_lat += wr_len;
        if (bresp_b[1]) e_err = 1;
        else begin
          nr = 1; e_lat += rd_len;
          if (rresp_res[1]) e_err = 1;
          else begin
            exp_result = prod[31:0]; nr = 2; e_lat += rd_len;
            if (rresp_ovf[1]) e_err = 1;
            else exp_ovf = (prod[63:32] != 0);
          end
        end
      end
      run_op(a, b, got, lat, bsy);
      $display("rand %0d: a=%h b=%h result=%h ovf=%0d err=%0d lat=%0d", i, a, b, result, overflow, error, lat);
      checks++; if (!got) begin errors++; $display("FAIL rand_done[%0d] got 0 exp 1", i); end
      checks++; if (lat != e_lat) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", i, lat, e_lat); end
      checks++; if (error !== e_err) begin errors++; $display("FAIL rand_error[%0d] got %b exp %b", i, error, e_err); end
      checks++; if (result !== exp_result) begin errors++; $display("FAIL rand_result[%0d] got %h exp %h", i, result, exp_result); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_ovf[%0d] got %b exp %b", i, overflow, exp_ovf); end
      checks++;
      if (aw_log.size() != nw || w_log.size() != nw || rd_log.size() != nr) begin
        errors++; $display("FAIL rand_traffic[%0d] got aw=%0d w=%0d r=%0d exp %0d/%0d/%0d",
                           i, aw_log.size(), w_log.size(), rd_log.size(), nw, nw, nr);
      end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++; $display("FAIL rand_after[%0d] got done=%b busy=%b exp 0 0", i, done, busy);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal();
    test_skew();
    test_bresp_err();
    test_ar_timeout();
    test_start_ignored_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_seq_master.md
MULT_SEQ_MASTER -- requirements
Module: mult_seq_master

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 32, data bus width.
REQ-002 ADDR_WIDTH, 8, AXI address width.
REQ-003 BASE_ADDR, 0, multiplier peripheral base address.
REQ-004 TIMEOUT, 255, maximum wait in cycles per handshake phase, range 1..65535.
REQ-005 The block SHALL have these ports (name, direction, width, meaning). Reset is synchronous and active-low.
- m_axi_aclk, in, 1, the only clock.
- m_axi_aresetn, in, 1, synchronous reset, active low.
REQ-006 Command ports:
- start, in, 1, request one operation.
- op_a, in, DATA_WIDTH, operand A.
- op_b, in, DATA_WIDTH, operand B.
- busy, out, 1, an operation is in progress.
- done, out, 1, one-cycle completion pulse.
- result, out, DATA_WIDTH, product as read back from the peripheral.
- overflow, out, 1, overflow flag as read back from the peripheral.
- error, out, 1, the operation failed.
REQ-007 AXI-lite master ports:
- m_axi_awaddr/awvalid, out, ADDR_WIDTH/1.
- m_axi_awready, in, 1.
- m_axi_wdata/wstrb/wvalid, out, DATA_WIDTH/DATA_WIDTH/8/1.
- m_axi_wready, in, 1.
- m_axi_bresp/bvalid, in, 2/1.
- m_axi_bready, out, 1.
- m_axi_araddr/arvalid, out, ADDR_WIDTH/1.
- m_axi_arready, in, 1.
- m_axi_rdata/rresp/rvalid, in, DATA_WIDTH/2/1.
- m_axi_rready, out, 1.

Function
REQ-008 The state machine SHALL use these states: IDLE, WR_A, WB_A, WR_B, WB_B, AR_RES, R_RES, AR_OVF, R_OVF, FIN.
REQ-009 In IDLE, start=1 SHALL capture op_a and op_b, set busy=1 on the next cycle, clear error, and go to WR_A. start is ignored in every other state.
REQ-010 In WR_A the block SHALL drive awaddr=BASE_ADDR+16, wdata=captured A, and wstrb all ones, with awvalid and wvalid both asserted on entry.
REQ-011 Each of awvalid and wvalid SHALL stay high until its own ready is sampled high, then drop independently. The block SHALL leave WR_A once both handshakes are done, whether they complete in the same cycle or in different cycles.
REQ-012 In WB_A, bready SHALL be 1. A cycle with bvalid&bready SHALL complete the phase and move to WR_B.
REQ-013 WR_B and WB_B SHALL follow REQ-010 to REQ-012 with address BASE_ADDR+20 and captured B, then move to AR_RES.
REQ-014 In AR_RES, arvalid=1 with araddr=BASE_ADDR+24 until arready. In R_RES, rready=1, and rvalid&rready SHALL latch rdata into a result holding register.
REQ-015 AR_OVF and R_OVF SHALL follow REQ-014 with address BASE_ADDR+28 and latch rdata[0] into an overflow holding register.
REQ-016 Response check: bresp or rresp with bit1=1 (SLVERR/DECERR) SHALL set error. Values 00 and 01 are both success.
REQ-017 On the first error response, the sequence SHALL abort to FIN without issuing further transactions.
REQ-018 A phase counter SHALL reset to 0 on entry to every non-IDLE, non-FIN state and increment each cycle in that state.
REQ-019 When the phase counter reaches TIMEOUT with the phase incomplete, the block SHALL set error, deassert all valid and ready outputs, and go to FIN.
REQ-020 FIN SHALL last exactly one cycle with done=1, then return to IDLE with busy=0.
REQ-021 result and overflow SHALL hold their last latched values until the next read handshake updates them.
REQ-022 error SHALL stay set until the next accepted start.
REQ-023 Minimum latency from start to done, with all readies and valids returning the same cycle they are requested, SHALL be 10 cycles.
REQ-024 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-025 While m_axi_aresetn=0 at a clock edge, the block SHALL enter IDLE.
REQ-026 Reset SHALL drive busy, done, error, overflow, and every valid/ready output to 0, and result, awaddr, araddr, wdata, wstrb to 0.
REQ-027 Reset in mid-operation SHALL abandon the transaction immediately, with no done pulse.

Verification
REQ-028 Ideal slave, A=6, B=7 -> writes to 16 and 20, reads 24 and 28; result=42, overflow=0, done 10 cycles after start, error=0.
REQ-029 awready 3 cycles before wready, A=0xFFFF_FFFF, B=2, peripheral returns 0xFFFF_FFFE and overflow 1 -> one write per address, result=0xFFFF_FFFE, overflow=1.
REQ-030 Slave returns bresp=10 on the operand-B write -> no AR issued, done with error=1, result unchanged.
REQ-031 arready never asserted, TIMEOUT=4 -> arvalid drops after 4 cycles in AR_RES, done=1, error=1.
REQ-032 start pulsed during WB_A, and reset asserted during R_RES -> second start ignored; after reset all outputs are 0, no done pulse, and the next start runs normally.
